// File: rtl/riscv_decoder_pkg.sv
// Shared types for the RV32I field decoder: format codes, opcodes and the decoded-word record.
package riscv_decoder_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R    = 3'd1,
    FMT_I    = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6
  } fmt_e;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    fmt_e        fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/riscv_imm_gen.sv
// Combinational immediate builder: picks the bit scramble for the decoded format.
import riscv_decoder_pkg::*;

module riscv_imm_gen (
  input  fmt_e        fmt_i,
  input  logic [31:7] instr_i,
  output logic [31:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (fmt_i)
      FMT_I: imm_o = sext12(instr_i[31:20]);
      FMT_S: imm_o = sext12({instr_i[31:25], instr_i[11:7]});
      FMT_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                      instr_i[11:8], 1'b0};
      FMT_U: imm_o = {instr_i[31:12], 12'b0};
      FMT_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                      instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/riscv_instr_decoder.sv
// Registered RV32I field decoder: classify opcode, zero unused fields, one register stage.
import riscv_decoder_pkg::*;

module riscv_instr_decoder (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] instr_i,
  output fmt_e        format_o,
  output logic [6:0]  op_o,
  output logic [2:0]  funct_3_o,
  output logic [6:0]  funct_7_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [31:0] imm_o,
  output logic        illegal_o
);

  dec_t        w_dec;
  dec_t        r_dec;
  logic [31:0] w_imm;

  always_comb begin
    w_dec         = '0;
    w_dec.fmt     = FMT_NONE;
    w_dec.op      = instr_i[6:0];
    case (instr_i[6:0])
      OPC_OP: begin
        w_dec.fmt = FMT_R;
        w_dec.rd  = instr_i[11:7];
        w_dec.rs1 = instr_i[19:15];
        w_dec.rs2 = instr_i[24:20];
        w_dec.f3  = instr_i[14:12];
        w_dec.f7  = instr_i[31:25];
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: begin
        w_dec.fmt = FMT_I;
        w_dec.rd  = instr_i[11:7];
        w_dec.rs1 = instr_i[19:15];
        w_dec.f3  = instr_i[14:12];
        // shift-immediates carry the arithmetic/logical select in funct7
        if (instr_i[6:0] == OPC_OP_IMM && instr_i[13:12] == 2'b01)
          w_dec.f7 = instr_i[31:25];
      end
      OPC_STORE, OPC_BRANCH: begin
        w_dec.fmt = (instr_i[6:0] == OPC_STORE) ? FMT_S : FMT_B;
        w_dec.rs1 = instr_i[19:15];
        w_dec.rs2 = instr_i[24:20];
        w_dec.f3  = instr_i[14:12];
      end
      OPC_LUI, OPC_AUIPC: begin
        w_dec.fmt = FMT_U;
        w_dec.rd  = instr_i[11:7];
      end
      OPC_JAL: begin
        w_dec.fmt = FMT_J;
        w_dec.rd  = instr_i[11:7];
      end
      default: w_dec.illegal = 1'b1;
    endcase
    w_dec.imm = w_imm;
  end

  riscv_imm_gen u_imm_gen (
    .fmt_i   (w_dec.fmt),
    .instr_i (instr_i[31:7]),
    .imm_o   (w_imm)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_dec <= '0;
    else         r_dec <= w_dec;
  end

  assign format_o  = r_dec.fmt;
  assign op_o      = r_dec.op;
  assign funct_3_o = r_dec.f3;
  assign funct_7_o = r_dec.f7;
  assign rd_o      = r_dec.rd;
  assign rs1_o     = r_dec.rs1;
  assign rs2_o     = r_dec.rs2;
  assign imm_o     = r_dec.imm;
  assign illegal_o = r_dec.illegal;

endmodule

// File: tb/tb_riscv_instr_decoder.sv
// Directed plus random checks of the registered decoder against an arithmetic reference model.
import riscv_decoder_pkg::*;

module tb_riscv_instr_decoder;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] instr_i = '0;
  fmt_e        format_o;
  logic [6:0]  op_o;
  logic [2:0]  funct_3_o;
  logic [6:0]  funct_7_o;
  logic [4:0]  rd_o, rs1_o, rs2_o;
  logic [31:0] imm_o;
  logic        illegal_o;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int unsigned fmt, op, f3, f7, rd, rs1, rs2, imm, ill;
  } exp_t;

  riscv_instr_decoder dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .instr_i(instr_i), .format_o(format_o), .op_o(op_o),
    .funct_3_o(funct_3_o), .funct_7_o(funct_7_o), .rd_o(rd_o), .rs1_o(rs1_o),
    .rs2_o(rs2_o), .imm_o(imm_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: format from the opcode table, fields from per-format use lists,
  // immediates assembled with signed shifts and adds rather than concatenation.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    int   s;
    bit   use_rd, use_rs1, use_rs2, use_f3, use_f7;
    s = int'(w);
    e = '{default: 0};
    e.op = w[6:0];
    case (w[6:0])
      7'h33:                      e.fmt = 1;
      7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: e.fmt = 2;
      7'h23:                      e.fmt = 3;
      7'h63:                      e.fmt = 4;
      7'h37, 7'h17:               e.fmt = 5;
      7'h6F:                      e.fmt = 6;
      default:                    e.ill = 1;
    endcase
    use_rd  = e.fmt inside {1, 2, 5, 6};
    use_rs1 = e.fmt inside {1, 2, 3, 4};
    use_rs2 = e.fmt inside {1, 3, 4};
    use_f3  = e.fmt inside {1, 2, 3, 4};
    use_f7  = (e.fmt == 1) || (w[6:0] == 7'h13 && (w[14:12] == 3'd1 || w[14:12] == 3'd5));
    if (use_rd)  e.rd  = w[11:7];
    if (use_rs1) e.rs1 = w[19:15];
    if (use_rs2) e.rs2 = w[24:20];
    if (use_f3)  e.f3  = w[14:12];
    if (use_f7)  e.f7  = w[31:25];
    case (e.fmt)
      2: e.imm = s >>> 20;
      3: e.imm = ((s >>> 25) * 32) + int'(w[11:7]);
      4: e.imm = ((s >>> 31) * 4096) + int'(w[7]) * 2048 + int'(w[30:25]) * 32
                 + int'(w[11:8]) * 2;
      5: e.imm = w & 32'hFFFFF000;
      6: e.imm = ((s >>> 31) * (1 << 20)) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                 + int'(w[30:21]) * 2;
      default: e.imm = 0;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, ".fmt"}, int'(format_o), e.fmt);
    chk({tag, ".op"},  op_o,      e.op);
    chk({tag, ".f3"},  funct_3_o, e.f3);
    chk({tag, ".f7"},  funct_7_o, e.f7);
    chk({tag, ".rd"},  rd_o,      e.rd);
    chk({tag, ".rs1"}, rs1_o,     e.rs1);
    chk({tag, ".rs2"}, rs2_o,     e.rs2);
    chk({tag, ".imm"}, imm_o,     e.imm);
    chk({tag, ".ill"}, illegal_o, e.ill);
  endtask

  task automatic step(input logic [31:0] w, input string tag);
    @(negedge clk_i);
    instr_i = w;
    @(posedge clk_i);
    #1 check_all(tag, model(w));
  endtask

  exp_t zero_e;
  logic [31:0] words [8] = '{32'h002081B3, 32'hFFF10093, 32'h0020A423, 32'hFE000EE3,
                              32'h123452B7, 32'h001000EF, 32'h00000000, 32'hFFFFFFFF};
  logic [6:0] legal_ops [11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63,
                                 7'h37, 7'h17, 7'h6F};

  initial begin
    zero_e = '{default: 0};
    // reset held with an instruction present
    instr_i = 32'h002081B3;
    repeat (2) @(posedge clk_i);
    #1 check_all("rst_hold", zero_e);
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i);
    #1 check_all("rst_rel", model(32'h002081B3));
    chk("add.rd_const", rd_o, 3);
    chk("add.rs2_const", rs2_o, 2);

    // directed words with spec-given constants
    step(32'hFFF10093, "addi");
    chk("addi.imm_const", imm_o, 32'hFFFFFFFF);
    step(32'h0020A423, "sw");
    chk("sw.imm_const", imm_o, 8);
    chk("sw.f3_const", funct_3_o, 2);
    step(32'hFE000EE3, "beq");
    chk("beq.imm_const", imm_o, 32'hFFFFFFFC);
    chk("beq.fmt_const", int'(format_o), int'(FMT_B));
    step(32'h123452B7, "lui");
    chk("lui.imm_const", imm_o, 32'h12345000);
    step(32'h001000EF, "jal");
    chk("jal.imm_const", imm_o, 32'h00000800);
    step(32'h00000000, "zero");
    chk("zero.ill_const", illegal_o, 1);
    step(32'hFFFFFFFF, "ones");
    chk("ones.op_const", op_o, 7'h7F);
    step(32'h40515093, "srai");
    chk("srai.f7_const", funct_7_o, 7'h20);
    step(32'h40512093, "slti");

    // random legal-opcode words and fully random words
    for (int i = 0; i < 150; i++) begin
      logic [31:0] w;
      w = $urandom;
      w[6:0] = legal_ops[$urandom_range(0, 10)];
      step(w, "rnd_legal");
    end
    for (int i = 0; i < 100; i++) step($urandom, "rnd_any");

    // back-to-back stream with an asynchronous reset pulse mid-cycle
    for (int i = 0; i < 8; i++) begin
      step(words[i], "stream");
      if (i == 3) begin
        #2 rst_ni = 1'b0;
        #1 check_all("async_rst", zero_e);
        @(negedge clk_i) instr_i = words[4];
        @(posedge clk_i);
        #1 check_all("rst_held", zero_e);
        @(negedge clk_i) rst_ni = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
